conv_k_mem_read_gen: RTL
========================

Name: conv_k_mem_read_gen

Overview:
Parametrised weight-memory address generator for any convolution layer's kernel store. It issues NUM_PORTS parallel read addresses per cycle, one per kernel bank, and sweeps every tap of a kernel. Each kernel pass repeats REPEAT times, once per output pixel, and the block then steps to the next kernel group. It adds a start/valid/done handshake, downstream stall, configurable inter-pass bubbles, and a runtime base address. It sits between the layer controller and the kernel ROM/RAM read ports.

Parameters:
ADDR_W, 8, address width of each read port
KSIZE, 25, taps per kernel (5x5)
NUM_PORTS, 2, parallel read ports (kernel banks)
PORT_STRIDE, 75, address offset between consecutive ports
NUM_GROUPS, 3, kernel groups swept sequentially
GROUP_STRIDE, 25, address offset between consecutive groups
REPEAT, 64, passes over each kernel per group
GAP_CYCLES, 0, idle cycles inserted after each completed pass (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE
base  in  ADDR_W  base address, sampled on accepted start
ready  in  1  consumer accepts current addresses; low = stall
abort  in  1  synchronous return to IDLE, priority over all but reset
addr  out  NUM_PORTS*ADDR_W  port p at bits [p*ADDR_W +: ADDR_W]
valid  out  1  addr is meaningful this cycle
last_tap  out  1  current addresses are tap KSIZE-1 of a pass
busy  out  1  state is RUN or GAP
done  out  1  sweep complete; held until next start or reset

Behaviour:
- Reset (reset=0): state IDLE. tap, rep, grp, gap counters = 0. base_q = 0. valid = last_tap = busy = done = 0. addr = 0.
- States:
  - IDLE --start--> RUN.
  - RUN --pass end, GAP_CYCLES>0--> GAP.
  - RUN --pass end, GAP_CYCLES=0--> RUN (no bubble).
  - GAP --gap count = GAP_CYCLES-1--> RUN.
  - RUN --final address accepted--> DONE.
  - DONE --start--> RUN.
  - Any state --abort--> IDLE.
- Accepted start: latch base_q = base. Clear all counters and done. First valid address appears the next cycle (latency 1).
- addr[p] = base_q + grp*GROUP_STRIDE + tap + p*PORT_STRIDE, truncated to ADDR_W (modulo 2^ADDR_W, no saturation). addr is registered.
- valid = 1 exactly in RUN. An address is accepted when valid & ready.
- Stall: ready=0 in RUN holds addr, valid, last_tap and all counters unchanged.
- Counter advance on acceptance:
  - tap increments.
  - At tap=KSIZE-1, tap wraps to 0 and rep increments (pass end).
  - At rep=REPEAT-1, rep wraps and grp increments.
  - At grp=NUM_GROUPS-1, the sweep is complete.
- last_tap = valid & (tap == KSIZE-1).
- GAP: valid = 0, counters frozen, gap counter counts regardless of ready. Gap counter is cleared on entry.
- Completion: the cycle after the final acceptance, state = DONE, done = 1, valid = 0, busy = 0. addr holds its last value.
- start while busy: ignored. start and abort in the same cycle: abort wins, state IDLE.
- abort: takes effect next cycle. Clears done, valid and counters; keeps base_q.
- reset asserted mid-sweep: immediate return to reset values, independent of clk.
- Total accepted addresses per sweep = KSIZE*REPEAT*NUM_GROUPS (4800 at defaults). With ready held at 1 the sweep lasts 4800 + (KSIZE... no: REPEAT*NUM_GROUPS-1)*GAP_CYCLES cycles of busy, excluding the final pass's gap, which is not inserted.
- No gap is inserted after the last pass of the sweep.
- Elaboration checks: NUM_PORTS >= 1, KSIZE >= 1, GAP_CYCLES <= 15.

Test Plan:
- Defaults, base=0, ready=1, start pulse -> first cycle addr0=0, addr1=75. Tap 24 gives addr0=24, addr1=99 with last_tap=1. Next cycle addr0=0 (rep 1).
- Full default sweep -> 4800 valid cycles. After 1600 acceptances addr0=25/addr1=100; after 3200 acceptances addr0=50/addr1=125. Last address addr0=74, addr1=149. done=1 the following cycle and holds.
- GAP_CYCLES=3 -> after each last_tap acceptance, exactly 3 cycles with valid=0. Addresses resume at tap 0. No gap after the final pass.
- ready toggled 0/1 pseudo-randomly -> same 4800-address sequence as the unstalled run. addr stable while ready=0.
- base=200, ADDR_W=8 -> port1 tap0 group0 = (200+75) mod 256 = 19 (wrap-around).
- abort at acceptance 1000, then start -> next cycle IDLE with valid=0, done=0. Restart begins at addr0=base. Also: reset low mid-sweep -> all outputs 0 immediately. Also: start while busy -> sequence unaffected.

Source files
------------

// File: rtl/conv_k_mem_read_gen.sv
// conv_k_mem_read_gen: kernel-store read address generator sweeping taps, passes and groups
// across NUM_PORTS banks with start/valid/ready/done handshake and optional inter-pass gaps.
module conv_k_mem_read_gen #(
   parameter int ADDR_W       = 8,
   parameter int KSIZE        = 25,
   parameter int NUM_PORTS    = 2,
   parameter int PORT_STRIDE  = 75,
   parameter int NUM_GROUPS   = 3,
   parameter int GROUP_STRIDE = 25,
   parameter int REPEAT       = 64,
   parameter int GAP_CYCLES   = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             base,
   input  logic                          ready,
   input  logic                          abort,
   output logic [NUM_PORTS*ADDR_W-1:0]   addr,
   output logic                          valid,
   output logic                          last_tap,
   output logic                          busy,
   output logic                          done
);
   localparam int TW = KSIZE > 1 ? $clog2(KSIZE) : 1;
   localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1;
   localparam int GW = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1;

   generate
      if (NUM_PORTS < 1 || KSIZE < 1 || GAP_CYCLES > 15 || GAP_CYCLES < 0) begin : g_bad_params
         $error("conv_k_mem_read_gen: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   state_t                        state, state_n;
   logic [TW-1:0]                 tap, tap_n;
   logic [RW-1:0]                 rep, rep_n;
   logic [GW-1:0]                 grp, grp_n;
   logic [3:0]                    gap, gap_n;
   logic [ADDR_W-1:0]             base_q, base_n;
   logic [NUM_PORTS*ADDR_W-1:0]   addr_n;
   logic                          acc, pass_end, rep_end, fin, start_ok, upd;

   always_comb begin
      acc      = state == RUN && ready;
      pass_end = acc && tap == TW'(KSIZE-1);
      rep_end  = pass_end && rep == RW'(REPEAT-1);
      fin      = rep_end && grp == GW'(NUM_GROUPS-1);
      start_ok = start && (state == IDLE || state == DONE);
      state_n  = state;
      tap_n    = tap;
      rep_n    = rep;
      grp_n    = grp;
      gap_n    = gap;
      base_n   = base_q;
      upd      = 1'b0;
      if (abort) begin
         state_n = IDLE;
         tap_n   = '0;
         rep_n   = '0;
         grp_n   = '0;
         gap_n   = '0;
      end else if (start_ok) begin
         state_n = RUN;
         tap_n   = '0;
         rep_n   = '0;
         grp_n   = '0;
         gap_n   = '0;
         base_n  = base;
         upd     = 1'b1;
      end else if (fin) begin
         state_n = DONE;
      end else if (acc) begin
         tap_n = pass_end ? '0 : tap + 1'b1;
         rep_n = rep_end ? '0 : (pass_end ? rep + 1'b1 : rep);
         grp_n = rep_end ? grp + 1'b1 : grp;
         upd   = 1'b1;
         if (pass_end && GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n   = '0;
         end
      end else if (state == GAP) begin
         state_n = gap == 4'(GAP_CYCLES-1) ? RUN : GAP;
         gap_n   = gap + 4'd1;
      end
      // addresses are computed from the post-update counters so addr lines up with tap
      for (int p = 0; p < NUM_PORTS; p++)
         addr_n[p*ADDR_W +: ADDR_W] = upd ?
            ADDR_W'(int'(base_n) + int'(grp_n)*GROUP_STRIDE + int'(tap_n) + p*PORT_STRIDE) :
            addr[p*ADDR_W +: ADDR_W];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         tap    <= '0;
         rep    <= '0;
         grp    <= '0;
         gap    <= '0;
         base_q <= '0;
         addr   <= '0;
      end else begin
         state  <= state_n;
         tap    <= tap_n;
         rep    <= rep_n;
         grp    <= grp_n;
         gap    <= gap_n;
         base_q <= base_n;
         addr   <= addr_n;
      end
   end

   assign valid    = state == RUN;
   assign last_tap = valid && tap == TW'(KSIZE-1);
   assign busy     = state == RUN || state == GAP;
   assign done     = state == DONE;
endmodule
